// File: rtl/axis_host_bridge.sv
// Host-side bridge: buffers one input frame, streams it to the accelerator over AXI-Stream,
// captures the returned result frame and exposes it to the host through a registered read port.
module axis_host_bridge #(
  parameter int words        = 2,
  parameter int dataWidth    = 32,
  parameter int addressWidth = $clog2(words),
  parameter int timeout      = 64,
  parameter int toWidth      = $clog2(timeout + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic                    host_wr_en,
  input  logic [addressWidth-1:0] host_wr_addr,
  input  logic [dataWidth-1:0]    host_wr_data,
  input  logic [addressWidth-1:0] host_rd_addr,
  output logic [dataWidth-1:0]    host_rd_data,
  output logic                    acc_start,
  output logic                    acc_interrupt,
  output logic [dataWidth-1:0]    M_AXIS_TDATA,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic                    M_AXIS_TLAST,
  input  logic [dataWidth-1:0]    S_AXIS_TDATA,
  input  logic                    S_AXIS_TVALID,
  output logic                    S_AXIS_TREADY,
  input  logic                    S_AXIS_TLAST
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] SEND  = 3'd2;
  localparam logic [2:0] RECV  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [addressWidth-1:0] lastIdx = addressWidth'(words - 1);
  localparam logic [toWidth-1:0]      toLast  = toWidth'(timeout - 1);

  logic [2:0]              state;
  logic [addressWidth-1:0] txIdx;
  logic [addressWidth-1:0] rxIdx;
  logic [toWidth-1:0]      toCnt;
  logic [dataWidth-1:0]    inBuf  [words];
  logic [dataWidth-1:0]    resBuf [words];

  // Outputs decode straight from the state register so an async reset drops them at once.
  assign busy          = (state != IDLE);
  assign acc_start     = (state == START);
  assign acc_interrupt = (state == STOP);
  assign done          = (state == DONE);
  assign S_AXIS_TREADY = (state == RECV);
  assign M_AXIS_TVALID = (state == SEND);
  assign M_AXIS_TLAST  = (state == SEND) && (txIdx == lastIdx);
  assign M_AXIS_TDATA  = (state == SEND) ? inBuf[txIdx] : '0;

  always_ff @(posedge clk) begin
    if (state == IDLE && host_wr_en) begin
      inBuf[host_wr_addr] <= host_wr_data;
    end
    if (state == RECV && S_AXIS_TVALID) begin
      resBuf[rxIdx] <= S_AXIS_TDATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      txIdx        <= '0;
      rxIdx        <= '0;
      toCnt        <= '0;
      error        <= 1'b0;
      host_rd_data <= '0;
    end else begin
      host_rd_data <= resBuf[host_rd_addr];
      case (state)
        IDLE: begin
          if (go) begin
            state <= START;
            error <= 1'b0;
            txIdx <= '0;
            rxIdx <= '0;
            toCnt <= '0;
          end
        end
        START: state <= SEND;
        SEND: begin
          if (M_AXIS_TREADY) begin
            if (txIdx == lastIdx) begin
              txIdx <= '0;
              state <= RECV;
            end else begin
              txIdx <= txIdx + 1'b1;
            end
          end
        end
        RECV: begin
          if (S_AXIS_TVALID) begin
            toCnt <= '0;
            rxIdx <= (rxIdx == lastIdx) ? '0 : rxIdx + 1'b1;
            if (rxIdx == lastIdx || S_AXIS_TLAST) begin
              state <= STOP;
            end
          end else begin
            toCnt <= toCnt + 1'b1;
            // The timeout-th idle cycle aborts; toCnt reaches timeout on the same edge.
            if (toCnt == toLast) begin
              error <= 1'b1;
              state <= STOP;
            end
          end
        end
        STOP:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_host_bridge.sv
// Directed self-checking bench for axis_host_bridge (words=2, timeout=64).
module tb_axis_host_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        busy, done, error;
  logic        hostWrEn;
  logic [0:0]  hostWrAddr;
  logic [31:0] hostWrData;
  logic [0:0]  hostRdAddr;
  logic [31:0] hostRdData;
  logic        accStart, accInterrupt;
  logic [31:0] mData;
  logic        mValid, mReady, mLast;
  logic [31:0] sData;
  logic        sValid, sReady, sLast;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A = 32'hAAAA_0001;
  localparam logic [31:0] B = 32'hBBBB_0002;
  localparam logic [31:0] X = 32'hC0DE_0010;
  localparam logic [31:0] Y = 32'hC0DE_0020;
  localparam logic [31:0] Z = 32'hC0DE_0030;
  localparam logic [31:0] J = 32'hDEAD_BEEF;

  axis_host_bridge dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .error(error),
    .host_wr_en(hostWrEn), .host_wr_addr(hostWrAddr), .host_wr_data(hostWrData),
    .host_rd_addr(hostRdAddr), .host_rd_data(hostRdData),
    .acc_start(accStart), .acc_interrupt(accInterrupt),
    .M_AXIS_TDATA(mData), .M_AXIS_TVALID(mValid), .M_AXIS_TREADY(mReady), .M_AXIS_TLAST(mLast),
    .S_AXIS_TDATA(sData), .S_AXIS_TVALID(sValid), .S_AXIS_TREADY(sReady), .S_AXIS_TLAST(sLast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; hostWrEn = 1'b0; hostWrAddr = '0; hostWrData = '0;
    hostRdAddr = '0; mReady = 1'b0; sData = '0; sValid = 1'b0; sLast = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_tvalid", mValid, 0);
    check("rst_tdata", mData, 0);
    check("rst_tlast", mLast, 0);
    check("rst_sready", sReady, 0);
    check("rst_start", accStart, 0);
    check("rst_irq", accInterrupt, 0);
    check("rst_rddata", hostRdData, 0);
    rst = 1'b0;

    // Load input frame {A,B}
    hostWrEn = 1'b1; hostWrAddr = 1'b0; hostWrData = A; step();
    hostWrAddr = 1'b1; hostWrData = B; step();
    hostWrEn = 1'b0;

    // 1: free-flowing send
    go = 1'b1; mReady = 1'b1; step(); go = 1'b0;
    check("t1_start", accStart, 1);
    check("t1_start_busy", busy, 1);
    check("t1_start_novalid", mValid, 0);
    step();
    check("t1_start_once", accStart, 0);
    check("t1_beat0_valid", mValid, 1);
    check("t1_beat0_data", mData, A);
    check("t1_beat0_last", mLast, 0);
    step();
    check("t1_beat1_data", mData, B);
    check("t1_beat1_last", mLast, 1);
    step();
    check("t1_send_over", mValid, 0);
    check("t1_recv_ready", sReady, 1);

    // 3: receive {X,Y} with 2-cycle valid gaps
    step(); step();
    sValid = 1'b1; sData = X; step();
    sValid = 1'b0;
    check("t3_still_recv", sReady, 1);
    step(); step();
    sValid = 1'b1; sData = Y; step();
    sValid = 1'b0;
    check("t3_irq", accInterrupt, 1);
    check("t3_stop_noready", sReady, 0);
    check("t3_stop_nodone", done, 0);
    step();
    check("t3_done", done, 1);
    check("t3_irq_once", accInterrupt, 0);
    step();
    check("t3_idle", busy, 0);
    check("t3_done_once", done, 0);
    hostRdAddr = 1'b0; step();
    check("t3_res0", hostRdData, X);
    hostRdAddr = 1'b1; step();
    check("t3_res1", hostRdData, Y);

    // 2: stall on second beat
    go = 1'b1; step(); go = 1'b0;
    step();
    check("t2_beat0", mData, A);
    step();
    mReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_data", mData, B);
      check("t2_hold_last", mLast, 1);
      check("t2_hold_valid", mValid, 1);
    end
    mReady = 1'b1; step();
    check("t2_to_recv", sReady, 1);

    // 6: go and writes while busy are ignored; early TLAST ends frame
    go = 1'b1; hostWrEn = 1'b1; hostWrAddr = 1'b0; hostWrData = J; step();
    go = 1'b0; hostWrEn = 1'b0;
    check("t6_still_recv", sReady, 1);
    sValid = 1'b1; sLast = 1'b1; sData = Z; step();
    sValid = 1'b0; sLast = 1'b0;
    check("t6_early_irq", accInterrupt, 1);
    step();
    check("t6_done", done, 1);
    step();
    check("t6_idle", busy, 0);
    hostRdAddr = 1'b0; step();
    check("t6_res0", hostRdData, Z);
    hostRdAddr = 1'b1; step();
    check("t6_res1_kept", hostRdData, Y);

    // 4: receive timeout (also confirms the busy write was dropped)
    go = 1'b1; step(); go = 1'b0;
    step();
    check("t4_inbuf_kept", mData, A);
    step(); step();
    for (int i = 0; i < 63; i++) step();
    check("t4_pre_sready", sReady, 1);
    check("t4_pre_error", error, 0);
    step();
    check("t4_irq", accInterrupt, 1);
    check("t4_error", error, 1);
    step();
    check("t4_done", done, 1);
    step();
    check("t4_idle", busy, 0);
    check("t4_error_sticky", error, 1);

    // 5: reset mid-send, then restart from beat 0
    go = 1'b1; step(); go = 1'b0;
    check("t5_error_cleared", error, 0);
    step();
    check("t5_beat0", mData, A);
    step();
    check("t5_beat1", mData, B);
    #1 rst = 1'b1;
    #1;
    check("t5_async_valid", mValid, 0);
    check("t5_async_busy", busy, 0);
    step();
    check("t5_no_done", done, 0);
    rst = 1'b0;
    step();
    check("t5_no_done2", done, 0);
    go = 1'b1; step(); go = 1'b0;
    check("t5_restart", accStart, 1);
    step();
    check("t5_restart_beat0", mData, A);
    check("t5_restart_last", mLast, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
